// File: rtl/pixel_pack_writer_pkg.sv
// Shared constants and types for the pixel packer: slot layout, play-window geometry
// and FSM state encoding.
package pixel_pack_writer_pkg;

  localparam int PIX_PER_WORD = 5;
  localparam int SLOT_W       = 3;
  localparam int PACK_W       = PIX_PER_WORD * SLOT_W;
  localparam int WORD_W       = 16;

  localparam int XPOS_START = 192;
  localparam int XPOS_END   = 448;
  localparam int YPOS_START = 48;
  localparam int YPOS_END   = 432;
  localparam int WINDOW_PIX = (XPOS_END - XPOS_START) * (YPOS_END - YPOS_START);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_PUSH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Lowest bit of slot s inside the pack register (3*s).
  function automatic logic [3:0] slot_lsb(input logic [2:0] s);
    return {1'b0, s} + {s, 1'b0};
  endfunction

endpackage

// File: rtl/pixel_pack_writer.sv
// Packs 3-bit RGB pixels five to a 16-bit word and pushes each word with its
// frame-memory word address into the display FIFO.
module pixel_pack_writer
  import pixel_pack_writer_pkg::*;
#(
  parameter int PIX_PER_FRAME = WINDOW_PIX,
  parameter int PCNT_W        = 17,
  parameter int ADDR_W        = 15
) (
  input  logic              clk_20MHz,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [2:0]        pix_rgb,
  output logic              pix_ready,
  input  logic              fifo_full,
  output logic              write_fifo,
  output logic [WORD_W-1:0] fifo_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              frame_done,
  output logic [1:0]        dbg_state
);

  localparam logic [PCNT_W-1:0] LAST_CNT  = PCNT_W'(PIX_PER_FRAME - 1);
  localparam logic [PCNT_W-1:0] PPF_CNT   = PCNT_W'(PIX_PER_FRAME);
  localparam logic [2:0]        LAST_SLOT = 3'(PIX_PER_WORD - 1);

  state_e              state_q, state_d;
  logic [2:0]          slot_q, slot_d;
  logic [PCNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [PACK_W-1:0]   pack_q, pack_d;
  logic                last_q, last_d;
  logic                write_q, write_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic                done_q, done_d;

  // Pixel handshake: a pixel transfers on a rising edge where pix_valid and pix_ready
  // are both 1; pix_ready depends only on state, never on pix_valid.
  assign pix_ready  = (state_q == ST_PACK);
  assign write_fifo = write_q;
  assign fifo_data  = data_q;
  assign mem_addr   = maddr_q;
  assign frame_done = done_q;
  assign dbg_state  = state_q;

  always_ff @(posedge clk_20MHz or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      slot_q    <= '0;
      pix_cnt_q <= '0;
      addr_q    <= '0;
      pack_q    <= '0;
      last_q    <= 1'b0;
      write_q   <= 1'b0;
      data_q    <= '0;
      maddr_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      pix_cnt_q <= pix_cnt_d;
      addr_q    <= addr_d;
      pack_q    <= pack_d;
      last_q    <= last_d;
      write_q   <= write_d;
      data_q    <= data_d;
      maddr_q   <= maddr_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    pix_cnt_d = pix_cnt_q;
    addr_d    = addr_q;
    pack_d    = pack_q;
    last_d    = last_q;
    write_d   = 1'b0;
    data_d    = data_q;
    maddr_d   = maddr_q;
    done_d    = 1'b0;

    // A restart wins over any accept or push on the same edge.
    if (frame_start) begin
      state_d   = ST_PACK;
      slot_d    = '0;
      pix_cnt_d = '0;
      addr_d    = '0;
      pack_d    = '0;
      last_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_PACK: begin
          if (pix_valid) begin
            pack_d[slot_lsb(slot_q) +: SLOT_W] = pix_rgb;
            slot_d = slot_q + 3'd1;
            if (pix_cnt_q != PPF_CNT) pix_cnt_d = pix_cnt_q + PCNT_W'(1);
            if (slot_q == LAST_SLOT || pix_cnt_q == LAST_CNT) begin
              state_d = ST_PUSH;
              last_d  = (pix_cnt_q == LAST_CNT);
            end
          end
        end
        ST_PUSH: begin
          if (!fifo_full) begin
            write_d = 1'b1;
            data_d  = {1'b0, pack_q};
            maddr_d = addr_q;
            addr_d  = addr_q + ADDR_W'(1);
            slot_d  = '0;
            pack_d  = '0;
            state_d = last_q ? ST_DONE : ST_PACK;
          end
        end
        ST_DONE: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule
